output_vc_credit_ctrl: RTL and testbench

OUTPUT_VC_CREDIT_CTRL -- requirements
Module: output_vc_credit_ctrl

---
 rtl/output_vc_credit_ctrl.sv | 112 +++++++++++
 tb/tb_output_vc_credit_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/output_vc_credit_ctrl.sv
// Output-VC state and credit tracking for a wormhole router: per-VC IDLE/ACTIVE/DRAIN
// state plus downstream credit counters, with a sticky protocol-error flag.
module output_vc_credit_ctrl #(
   parameter int NUM_PORTS = 5,
   parameter int NUM_VC    = 4,
   parameter int BUF_DEPTH = 4
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [NUM_PORTS*NUM_VC-1:0]                  vc_alloc,
   input  logic [NUM_PORTS-1:0]                         flit_sent,
   input  logic [NUM_PORTS*((NUM_VC > 1) ? $clog2(NUM_VC) : 1)-1:0]     flit_sent_vc,
   input  logic [NUM_PORTS-1:0]                         flit_sent_tail,
   input  logic [NUM_PORTS-2:0]                         dwnstr_router_increment,
   input  logic [(NUM_PORTS-1)*((NUM_VC > 1) ? $clog2(NUM_VC) : 1)-1:0] dwnstr_credit_vc,
   output logic [NUM_PORTS*NUM_VC-1:0]                  available_op_vcs,
   output logic [NUM_PORTS*NUM_VC-1:0]                  credit_ok,
   output logic                                         credit_err
);

   localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int N_OVC = NUM_PORTS * NUM_VC;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } vc_state_t;

   // The local port has no credit return; pad it with a permanently idle slot
   logic [NUM_PORTS-1:0]      w_ret_pad;
   logic [NUM_PORTS*VC_W-1:0] w_ret_vc_pad;
   logic [N_OVC-1:0]          w_vc_err;
   logic                      r_err;

   assign w_ret_pad    = {1'b0, dwnstr_router_increment};
   assign w_ret_vc_pad = {{VC_W{1'b0}}, dwnstr_credit_vc};

   for (genvar i = 0; i < N_OVC; i++) begin : g_ovc
      localparam int P     = i / NUM_VC;
      localparam int V     = i % NUM_VC;
      localparam bit LOCAL = (P == NUM_PORTS - 1);

      vc_state_t        r_st;
      vc_state_t        w_st_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             w_send;
      logic             w_ret;
      logic             w_accept;
      logic             w_err;

      assign w_send = flit_sent[P] && (flit_sent_vc[P*VC_W +: VC_W] == VC_W'(V));
      assign w_ret  = w_ret_pad[P] && (w_ret_vc_pad[P*VC_W +: VC_W] == VC_W'(V));

      always_comb begin
         w_st_nxt  = r_st;
         w_cnt_nxt = r_cnt;
         w_accept  = 1'b0;
         w_err     = 1'b0;

         if (vc_alloc[i]) begin
            if (r_st == ST_IDLE) w_st_nxt = ST_ACTIVE;
            else                 w_err    = 1'b1;
         end

         // All credits home: the downstream buffer is empty, release the VC
         if ((r_st == ST_DRAIN) && (r_cnt == CNT_W'(BUF_DEPTH)))
            w_st_nxt = ST_IDLE;

         if (w_send) begin
            if ((r_st == ST_ACTIVE) && (LOCAL || (r_cnt != '0))) begin
               w_accept = 1'b1;
               if (flit_sent_tail[P]) w_st_nxt = ST_DRAIN;
            end else if (!LOCAL) begin
               w_err = 1'b1;
            end
         end

         // A send and a return on the same VC cancel out
         if (w_accept && !w_ret && !LOCAL) begin
            w_cnt_nxt = r_cnt - 1'b1;
         end else if (w_ret && !w_accept) begin
            if (r_cnt == CNT_W'(BUF_DEPTH)) w_err     = 1'b1;
            else                            w_cnt_nxt = r_cnt + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            r_st  <= ST_IDLE;
            r_cnt <= CNT_W'(BUF_DEPTH);
         end else begin
            r_st  <= w_st_nxt;
            r_cnt <= w_cnt_nxt;
         end
      end

      assign w_vc_err[i]         = w_err;
      assign available_op_vcs[i] = (r_st == ST_IDLE);
      assign credit_ok[i]        = (r_st == ST_ACTIVE) && (r_cnt != '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) r_err <= 1'b0;
      else        r_err <= r_err | (|w_vc_err);
   end

   assign credit_err = r_err;

endmodule

// File: tb/tb_output_vc_credit_ctrl.sv
// Directed bench for output_vc_credit_ctrl at default parameters (5 ports x 4 VCs, depth 4).
module tb_output_vc_credit_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] vc_alloc;
   logic [4:0]  flit_sent;
   logic [9:0]  flit_sent_vc;
   logic [4:0]  flit_sent_tail;
   logic [3:0]  dwnstr_router_increment;
   logic [7:0]  dwnstr_credit_vc;
   logic [19:0] available_op_vcs;
   logic [19:0] credit_ok;
   logic        credit_err;

   int n_checks = 0;
   int n_errors = 0;

   output_vc_credit_ctrl dut (
      .clk                     (clk),
      .reset                   (reset),
      .vc_alloc                (vc_alloc),
      .flit_sent               (flit_sent),
      .flit_sent_vc            (flit_sent_vc),
      .flit_sent_tail          (flit_sent_tail),
      .dwnstr_router_increment (dwnstr_router_increment),
      .dwnstr_credit_vc        (dwnstr_credit_vc),
      .available_op_vcs        (available_op_vcs),
      .credit_ok               (credit_ok),
      .credit_err              (credit_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic [19:0] alloc;
      logic [4:0]  fs;
      logic [9:0]  fsvc;
      logic [4:0]  tail;
      logic [3:0]  inc;
      logic [7:0]  cvc;
      logic [19:0] ea;
      logic [19:0] eo;
      logic        ee;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst_n, input logic [19:0] alloc,
                               input logic [4:0] fs, input logic [9:0] fsvc,
                               input logic [4:0] tail, input logic [3:0] inc,
                               input logic [7:0] cvc, input logic [19:0] ea,
                               input logic [19:0] eo, input logic ee, input string nm);
      vec_t v;
      v.rst_n = rst_n; v.alloc = alloc; v.fs = fs; v.fsvc = fsvc; v.tail = tail;
      v.inc = inc; v.cvc = cvc; v.ea = ea; v.eo = eo; v.ee = ee; v.nm = nm;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %05h expected %05h", nm, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      reset                   = v.rst_n;
      vc_alloc                = v.alloc;
      flit_sent               = v.fs;
      flit_sent_vc            = v.fsvc;
      flit_sent_tail          = v.tail;
      dwnstr_router_increment = v.inc;
      dwnstr_credit_vc        = v.cvc;
      @(posedge clk);
      #1;
      chk({v.nm, ".avail"}, available_op_vcs, v.ea);
      chk({v.nm, ".ok"},    credit_ok,        v.eo);
      chk({v.nm, ".err"},   {19'd0, credit_err}, {19'd0, v.ee});
   endtask

   initial begin
      reset = 1'b0; vc_alloc = '0; flit_sent = '0; flit_sent_vc = '0;
      flit_sent_tail = '0; dwnstr_router_increment = '0; dwnstr_credit_vc = '0;
      #2;

      // Reset (ignoring a simultaneous alloc), then drain port1 VC0 of credits
      tbl.push_back(mk(0, 20'h00010, 0, 0, 0, 0, 0, 20'hFFFFF, 20'h00000, 0, "reset"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20'hFFFFF, 20'h00000, 0, "idle0"));
      tbl.push_back(mk(1, 20'h00010, 0, 0, 0, 0, 0, 20'hFFFEF, 20'h00010, 0, "alloc4"));
      tbl.push_back(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, 20'h00010, 0, "send1"));
      tbl.push_back(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, 20'h00010, 0, "send2"));
      tbl.push_back(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, 20'h00010, 0, "send3"));
      tbl.push_back(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, 20'h00000, 0, "send4"));
      tbl.push_back(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, 20'h00000, 1, "send5_nocred"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4'h2, 0, 20'hFFFEF, 20'h00010, 1, "ret_after0"));
      tbl.push_back(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, 20'h00000, 1, "send_last"));
      // Tail send and credit return collide on port1 VC0 at count 2
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 20'hFFFFF, 20'h00000, 0, "reset2"));
      tbl.push_back(mk(1, 20'h00010, 0, 0, 0, 0, 0, 20'hFFFEF, 20'h00010, 0, "alloc4b"));
      tbl.push_back(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, 20'h00010, 0, "sendb1"));
      tbl.push_back(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, 20'h00010, 0, "sendb2"));
      tbl.push_back(mk(1, 0, 5'h02, 0, 5'h02, 4'h2, 0, 20'hFFFEF, 20'h00000, 0, "tail_ret"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20'hFFFEF, 20'h00000, 0, "drain_c2"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4'h2, 0, 20'hFFFEF, 20'h00000, 0, "drain_c3"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4'h2, 0, 20'hFFFEF, 20'h00000, 0, "drain_c4"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20'hFFFFF, 20'h00000, 0, "drain_idle"));
      // Saturating return on port0 VC2, then prove its count stayed at 4
      tbl.push_back(mk(1, 0, 0, 0, 0, 4'h1, 8'h02, 20'hFFFFF, 20'h00000, 1, "ret_sat"));
      tbl.push_back(mk(1, 20'h00004, 0, 0, 0, 0, 0, 20'hFFFFB, 20'h00004, 1, "alloc2"));
      tbl.push_back(mk(1, 0, 5'h01, 10'h002, 0, 0, 0, 20'hFFFFB, 20'h00004, 1, "p0s1"));
      tbl.push_back(mk(1, 0, 5'h01, 10'h002, 0, 0, 0, 20'hFFFFB, 20'h00004, 1, "p0s2"));
      tbl.push_back(mk(1, 0, 5'h01, 10'h002, 0, 0, 0, 20'hFFFFB, 20'h00004, 1, "p0s3"));
      tbl.push_back(mk(1, 0, 5'h01, 10'h002, 0, 0, 0, 20'hFFFFB, 20'h00000, 1, "p0s4"));
      // Re-allocating an ACTIVE VC
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 20'hFFFFF, 20'h00000, 0, "reset3"));
      tbl.push_back(mk(1, 20'h00004, 0, 0, 0, 0, 0, 20'hFFFFB, 20'h00004, 0, "alloc2b"));
      tbl.push_back(mk(1, 20'h00004, 0, 0, 0, 0, 0, 20'hFFFFB, 20'h00004, 1, "realloc"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 20'hFFFFF, 20'h00000, 0, "reset4"));
      // Concurrent activity on ports 0, 1 and the local port
      tbl.push_back(mk(1, 20'h80081, 0, 0, 0, 0, 0, 20'h7FF7E, 20'h80081, 0, "multi_alloc"));
      tbl.push_back(mk(1, 0, 5'h13, 10'h30C, 5'h13, 0, 0, 20'h7FF7E, 20'h00000, 0, "multi_tail"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 4'h3, 8'h0C, 20'hFFF7E, 20'h00000, 0, "multi_ret"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20'hFFFFF, 20'h00000, 0, "multi_idle"));
      // Reset in the middle of a packet
      tbl.push_back(mk(1, 20'h00010, 0, 0, 0, 0, 0, 20'hFFFEF, 20'h00010, 0, "mid_alloc"));
      tbl.push_back(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, 20'h00010, 0, "mid_send"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 20'hFFFFF, 20'h00000, 0, "mid_reset"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20'hFFFFF, 20'h00000, 0, "mid_idle"));

      foreach (tbl[k]) step(tbl[k]);

      // Local port VC1: unlimited credits across 10 bodies and a tail
      step(mk(1, 20'h20000, 0, 0, 0, 0, 0, 20'hDFFFF, 20'h20000, 0, "loc_alloc"));
      for (int s = 0; s < 10; s++)
         step(mk(1, 0, 5'h10, 10'h100, 0, 0, 0, 20'hDFFFF, 20'h20000, 0, $sformatf("loc_send%0d", s)));
      step(mk(1, 0, 5'h10, 10'h100, 5'h10, 0, 0, 20'hDFFFF, 20'h00000, 0, "loc_tail"));
      step(mk(1, 0, 0, 0, 0, 0, 0, 20'hFFFFF, 20'h00000, 0, "loc_idle"));

      // Rejected send on an empty VC while a credit returns: only the return counts
      step(mk(1, 20'h00010, 0, 0, 0, 0, 0, 20'hFFFEF, 20'h00010, 0, "rj_alloc"));
      for (int s = 0; s < 4; s++)
         step(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, (s < 3) ? 20'h00010 : 20'h00000, 0,
                 $sformatf("rj_send%0d", s)));
      step(mk(1, 0, 5'h02, 0, 0, 4'h2, 0, 20'hFFFEF, 20'h00010, 1, "rj_send_ret"));
      step(mk(1, 0, 5'h02, 0, 0, 0, 0, 20'hFFFEF, 20'h00000, 1, "rj_send_one"));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
